// File: rtl/qpix_event_fifo_array_if.sv
// Event FIFO array bus: trigger/event/read-request inputs and read/status outputs.
// The master drives trigger, oLVDS and rd_req; the slave (the FIFO array) drives the rest.
interface qpix_event_fifo_array_if #(
  parameter int unsigned NCH  = 16,
  parameter int unsigned TS_W = 32
) ();
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic            trigger;
  logic [NCH-1:0]  oLVDS;
  logic [NCH-1:0]  rd_req;
  logic [TS_W-1:0] rd_data;
  logic [CW-1:0]   rd_ch;
  logic            rd_valid;
  logic [NCH-1:0]  empty;
  logic [NCH-1:0]  full;
  logic [NCH-1:0]  ovf;
  logic [TS_W-1:0] ts;

  modport master (
    output trigger, oLVDS, rd_req,
    input  rd_data, rd_ch, rd_valid, empty, full, ovf, ts
  );

  modport slave (
    input  trigger, oLVDS, rd_req,
    output rd_data, rd_ch, rd_valid, empty, full, ovf, ts
  );
endinterface

// File: rtl/qpix_event_fifo_array.sv
// Per-channel timestamp FIFOs fed by synchronized LVDS event edges while triggered,
// drained one word per cycle by a lowest-index-first read arbiter.
module qpix_event_fifo_array #(
  parameter int unsigned NCH   = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TS_W  = 32
) (
  input logic clk,
  input logic rst,
  qpix_event_fifo_array_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]  sync1, sync2, sync_prev, edge_q;
  logic            trig_prev;
  logic [TS_W-1:0] ts_q;
  logic [NCH-1:0]  rd_prev, pending;
  logic [PW-1:0]   wptr [NCH];
  logic [PW-1:0]   rptr [NCH];
  logic [TS_W-1:0] mem  [NCH][DEPTH];
  logic [NCH-1:0]  empty_q, full_q, ovf_q;
  logic [TS_W-1:0] rd_data_q;
  logic [CW-1:0]   rd_ch_q;
  logic            rd_valid_q;

  logic            trig_rise_c;
  logic [NCH-1:0]  rd_rise_c, grant_c, wr_c, wr_ok_c, pop_c;
  logic [CW-1:0]   sel_c;
  logic [PW-1:0]   wptr_n [NCH];
  logic [PW-1:0]   rptr_n [NCH];

  // Arbitration, write/pop qualification and next pointers
  always_comb begin
    trig_rise_c = bus.trigger & ~trig_prev;
    rd_rise_c   = bus.rd_req & ~rd_prev;
    grant_c     = '0;
    sel_c       = '0;
    // Descending scan so the lowest pending index is the one left standing
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_c = NCH'(1) << i;
        sel_c   = CW'(i);
      end
    end
    wr_c  = edge_q & {NCH{bus.trigger}};
    pop_c = grant_c & ~empty_q;
    for (int i = 0; i < int'(NCH); i++) begin
      wr_ok_c[i] = wr_c[i] & (~full_q[i] | pop_c[i]);
      wptr_n[i]  = wptr[i] + PW'(wr_ok_c[i]);
      rptr_n[i]  = rptr[i] + PW'(pop_c[i]);
    end
  end

  // Control, status and read-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      sync_prev  <= '0;
      edge_q     <= '0;
      trig_prev  <= 1'b0;
      ts_q       <= '0;
      rd_prev    <= '0;
      pending    <= '0;
      empty_q    <= '1;
      full_q     <= '0;
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_ch_q    <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < int'(NCH); i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      sync1     <= bus.oLVDS;
      sync2     <= sync1;
      sync_prev <= sync2;
      edge_q    <= sync2 & ~sync_prev;
      trig_prev <= bus.trigger;
      if (trig_rise_c) begin
        ts_q <= '0;
      end else if (bus.trigger) begin
        ts_q <= ts_q + TS_W'(1);
      end
      rd_prev <= bus.rd_req;
      // A new edge on an already-pending channel is absorbed
      pending <= (pending & ~grant_c) | (rd_rise_c & ~pending);
      ovf_q   <= (trig_rise_c ? '0 : ovf_q) | (wr_c & full_q & ~pop_c);
      rd_valid_q <= |pop_c;
      if (|pop_c) begin
        rd_data_q <= mem[sel_c][rptr[sel_c][AW-1:0]];
        rd_ch_q   <= sel_c;
      end
      for (int i = 0; i < int'(NCH); i++) begin
        wptr[i]    <= wptr_n[i];
        rptr[i]    <= rptr_n[i];
        empty_q[i] <= (wptr_n[i] == rptr_n[i]);
        full_q[i]  <= (wptr_n[i][AW] != rptr_n[i][AW]) &&
                      (wptr_n[i][AW-1:0] == rptr_n[i][AW-1:0]);
      end
    end
  end

  // Storage has no reset; validity is tracked entirely by the pointers
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NCH); i++) begin
      if (!rst && wr_ok_c[i]) begin
        mem[i][wptr[i][AW-1:0]] <= ts_q;
      end
    end
  end

  assign bus.ts       = ts_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_ch    = rd_ch_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_qpix_event_fifo_array.sv
// Scoreboard bench for qpix_event_fifo_array: capture, empty read, overflow,
// full write+pop, arbitration order, trigger gating and mid-operation reset.
module tb_qpix_event_fifo_array;
  localparam int unsigned NCH   = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TS_W  = 32;

  typedef struct packed {
    logic [3:0]      ch;
    logic [TS_W-1:0] data;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qpix_event_fifo_array_if #(.NCH(NCH), .TS_W(TS_W)) bus ();

  qpix_event_fifo_array #(.NCH(NCH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  rd_exp_t         sb [$];
  logic [TS_W-1:0] mfifo [NCH][DEPTH];
  int              mcnt  [NCH];
  logic [NCH-1:0]  movf;
  logic [TS_W-1:0] mts;
  logic            trig_d;
  logic [TS_W-1:0] exp_last = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference timestamp counter, driven only by the bench's own trigger/rst
  always @(posedge clk) begin
    if (rst) begin
      mts    = '0;
      trig_d = 1'b0;
    end else begin
      if (bus.trigger && !trig_d) mts = '0;
      else if (bus.trigger)       mts = mts + 1;
      trig_d = bus.trigger;
    end
  end

  // Read-port monitor: every rd_valid must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.rd_valid) begin
      if (sb.size() == 0) begin
        check("spurious_rd_valid", 64'(bus.rd_valid), 64'd0);
      end else begin
        rd_exp_t e;
        e = sb.pop_front();
        check("rd_ch", 64'(bus.rd_ch), 64'(e.ch));
        check("rd_data", 64'(bus.rd_data), 64'(e.data));
        exp_last = e.data;
      end
    end
  end

  task automatic model_push(input int ch, input logic [TS_W-1:0] v);
    if (mcnt[ch] < int'(DEPTH)) begin
      mfifo[ch][mcnt[ch]] = v;
      mcnt[ch]++;
    end else begin
      movf[ch] = 1'b1;
    end
  endtask

  task automatic model_pop(input int ch);
    rd_exp_t e;
    if (mcnt[ch] > 0) begin
      e.ch   = 4'(ch);
      e.data = mfifo[ch][0];
      for (int j = 0; j < int'(DEPTH) - 1; j++) mfifo[ch][j] = mfifo[ch][j+1];
      mcnt[ch]--;
      sb.push_back(e);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < int'(NCH); c++) mcnt[c] = 0;
    movf = '0;
  endtask

  // Event pulse, 2 cycles high; stored value is the ts three cycles later
  task automatic ev(input logic [NCH-1:0] mask);
    bus.oLVDS = mask;
    for (int c = 0; c < int'(NCH); c++)
      if (mask[c] && bus.trigger) model_push(c, mts + 3);
    tick(2);
    bus.oLVDS = '0;
    tick(2);
  endtask

  task automatic rd(input logic [NCH-1:0] mask);
    bus.rd_req = mask;
    for (int c = 0; c < int'(NCH); c++)
      if (mask[c]) model_pop(c);
    tick(1);
    bus.rd_req = '0;
  endtask

  task automatic wait_ts(input logic [TS_W-1:0] v);
    int n;
    n = 0;
    while (mts != v && n < 200) begin
      tick(1);
      n++;
    end
    check("ts_at_wait", 64'(bus.ts), 64'(v));
  endtask

  initial begin
    logic [TS_W-1:0] newv;
    int n;
    bus.trigger = 1'b0;
    bus.oLVDS   = '0;
    bus.rd_req  = '0;
    rst         = 1'b1;
    model_clear();
    tick(2);
    check("rst_ts", 64'(bus.ts), 64'd0);
    check("rst_rd_data", 64'(bus.rd_data), 64'd0);
    check("rst_rd_ch", 64'(bus.rd_ch), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_empty", 64'(bus.empty), 64'hFFFF);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    rst = 1'b0;
    tick(1);

    // Basic capture at ts=10 and ts=40, then two reads
    bus.trigger = 1'b1;
    wait_ts(10);
    ev(16'h0001);
    wait_ts(40);
    ev(16'h0001);
    check("ts_track", 64'(bus.ts), 64'(mts));
    rd(16'h0001); tick(2);
    rd(16'h0001); tick(3);
    check("cap_last_data", 64'(bus.rd_data), 64'd43);
    check("empty0_after", 64'(bus.empty[0]), 64'd1);

    // Empty read: nothing returned, rd_data held
    rd(16'h0001); tick(3);
    check("empty_rd_data_hold", 64'(bus.rd_data), 64'(exp_last));
    check("empty_rd_ch_hold", 64'(bus.rd_ch), 64'd0);

    // Overflow on channel 3
    for (int k = 0; k < 5; k++) ev(16'h0008);
    check("ovf_full3", 64'(bus.full[3]), 64'd1);
    check("ovf_flag3", 64'(bus.ovf[3]), 64'd1);
    check("ovf_vec", 64'(bus.ovf), 64'(movf));
    for (int k = 0; k < 5; k++) begin
      rd(16'h0008); tick(2);
    end
    check("ovf_empty3", 64'(bus.empty[3]), 64'd1);
    check("ovf_sticky3", 64'(bus.ovf[3]), 64'd1);

    // Simultaneous write and pop on full channel 2
    for (int k = 0; k < 4; k++) ev(16'h0004);
    check("wp_full2_before", 64'(bus.full[2]), 64'd1);
    bus.oLVDS = 16'h0004;
    newv = mts + 3;
    tick(2);
    bus.oLVDS = '0;
    bus.rd_req = 16'h0004;
    model_pop(2);
    model_push(2, newv);
    tick(1);
    bus.rd_req = '0;
    tick(3);
    check("wp_full2_after", 64'(bus.full[2]), 64'd1);
    check("wp_ovf2", 64'(bus.ovf[2]), 64'd0);
    for (int k = 0; k < 4; k++) begin
      rd(16'h0004); tick(2);
    end
    check("wp_newest_last", 64'(exp_last), 64'(newv));
    check("wp_empty2", 64'(bus.empty[2]), 64'd1);

    // Arbitration: requests on 15, 7, 1 in one cycle
    ev(16'hFFFE);
    bus.rd_req = 16'h8082;
    model_pop(1); model_pop(7); model_pop(15);
    tick(1);
    bus.rd_req = '0;
    tick(1);
    check("arb_v0", 64'(bus.rd_valid), 64'd1);
    tick(1);
    check("arb_v1", 64'(bus.rd_valid), 64'd1);
    tick(1);
    check("arb_v2", 64'(bus.rd_valid), 64'd1);
    tick(1);
    check("arb_v3_idle", 64'(bus.rd_valid), 64'd0);

    // ovf survives trigger low, clears on rise; FIFO contents survive
    bus.trigger = 1'b0;
    tick(2);
    check("ovf_hold_trig0", 64'(bus.ovf), 64'(movf));
    bus.trigger = 1'b1;
    movf = '0;
    tick(2);
    check("ovf_clr_trig_rise", 64'(bus.ovf), 64'(movf));
    check("ts_restart", 64'(bus.ts), 64'(mts));
    rd(16'h0010); tick(2);
    rd(16'h0020); tick(2);
    check("ch5_drained", 64'(bus.empty[5]), 64'd1);

    // Trigger gating, then reset with 2 words and a read pending on channel 5
    bus.trigger = 1'b0;
    tick(1);
    ev(16'h0020);
    tick(2);
    check("gated_empty5", 64'(bus.empty[5]), 64'd1);
    bus.trigger = 1'b1;
    tick(1);
    ev(16'h0020);
    ev(16'h0020);
    check("ch5_loaded", 64'(bus.empty[5]), 64'd0);
    bus.rd_req = 16'h0020;
    tick(1);
    rst = 1'b1;
    bus.rd_req = '0;
    model_clear();
    exp_last = '0;
    tick(1);
    check("mid_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("mid_rst_ts", 64'(bus.ts), 64'd0);
    check("mid_rst_rd_data", 64'(bus.rd_data), 64'd0);
    check("mid_rst_rd_ch", 64'(bus.rd_ch), 64'd0);
    check("mid_rst_empty", 64'(bus.empty), 64'hFFFF);
    check("mid_rst_full", 64'(bus.full), 64'd0);
    check("mid_rst_ovf", 64'(bus.ovf), 64'd0);
    tick(1);
    rst = 1'b0;
    tick(6);
    check("post_rst_rd_data", 64'(bus.rd_data), 64'd0);
    check("post_rst_empty", 64'(bus.empty), 64'hFFFF);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick(1);
      n++;
    end
    check("sb_drain", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
